// File: rtl/ro_lap_timer.sv
// ro_lap_timer: ring-oscillator elapsed timer with wrap/saturate overflow and a lap-capture FIFO
// Ports: clk/rst_n oscillator clock and async active-low reset; clear/start/stop/lap/rd_en controls;
//        measuring, elapsed_count, lap_data/lap_valid/lap_full, sticky lap_dropped and overflow status.
module ro_lap_timer #(
    parameter int CNT_W   = 32,
    parameter int SHORT_W = 4,
    parameter int LAPS    = 4,
    parameter bit SAT     = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             start,
    input  logic             stop,
    input  logic             lap,
    input  logic             rd_en,
    output logic             measuring,
    output logic [CNT_W-1:0] elapsed_count,
    output logic [CNT_W-1:0] lap_data,
    output logic             lap_valid,
    output logic             lap_full,
    output logic             lap_dropped,
    output logic             overflow
);
    localparam int HI_W = CNT_W - SHORT_W;
    localparam int PW   = $clog2(LAPS);
    logic [SHORT_W-1:0] lo_q, lo_d;
    logic [HI_W-1:0]    hi_q, hi_d;
    logic [CNT_W-1:0]   count, elapsed_q, elapsed_d;
    logic               measuring_q, measuring_d, ovf_q, ovf_d, drop_q, drop_d;
    logic [PW:0]        wr_q, wr_d, rd_q, rd_d, occ;
    logic [CNT_W-1:0]   mem_q [LAPS];
    logic               inc, wrap, push_req, pop, push;

    assign count         = {hi_q, lo_q};
    // Pointers carry one extra bit so a full FIFO is distinguishable from an empty one.
    assign occ           = wr_q - rd_q;
    assign lap_valid     = occ != '0;
    assign lap_full      = occ == (PW+1)'(LAPS);
    assign lap_data      = lap_valid ? mem_q[rd_q[PW-1:0]] : '0;
    assign measuring     = measuring_q;
    assign elapsed_count = elapsed_q;
    assign lap_dropped   = drop_q;
    assign overflow      = ovf_q;

    always_comb begin
        inc         = measuring_q & ~clear & ~stop;
        wrap        = &count;
        push_req    = lap & inc;
        pop         = rd_en & lap_valid & ~clear;
        // A pop on the same edge frees the slot a full-FIFO push needs.
        push        = push_req & (~lap_full | pop);
        // High segment only advances on low-segment carry; saturating mode freezes at all-ones.
        {hi_d, lo_d} = clear ? '0 :
                       (inc && !(SAT && wrap)) ? {(&lo_q) ? hi_q + HI_W'(1) : hi_q, lo_q + SHORT_W'(1)} :
                       count;
        measuring_d = clear ? measuring_q : stop ? 1'b0 : start ? 1'b1 : measuring_q;
        elapsed_d   = clear ? '0 : stop ? count : elapsed_q;
        ovf_d       = ~clear & (ovf_q | (inc & wrap));
        drop_d      = ~clear & (drop_q | (push_req & lap_full & ~pop));
        wr_d        = clear ? '0 : wr_q + (PW+1)'(push);
        rd_d        = clear ? '0 : rd_q + (PW+1)'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_q        <= '0;
            hi_q        <= '0;
            elapsed_q   <= '0;
            measuring_q <= 1'b0;
            ovf_q       <= 1'b0;
            drop_q      <= 1'b0;
            wr_q        <= '0;
            rd_q        <= '0;
        end else begin
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            elapsed_q   <= elapsed_d;
            measuring_q <= measuring_d;
            ovf_q       <= ovf_d;
            drop_q      <= drop_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
        end
    end

    // Storage needs no reset: lap_data is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[PW-1:0]] <= count;
    end
endmodule

// File: tb/tb_ro_lap_timer.sv
// tb_ro_lap_timer: directed and randomized checks of ro_lap_timer (8-bit, wrap and saturate variants)
module tb_ro_lap_timer;
    localparam int CNT_W = 8;
    localparam int LAPS  = 4;
    localparam int MAXV  = 255;

    logic clk = 1'b0;
    logic rst_n, clear, start, stop, lap, rd_en;
    logic             meas [2];
    logic [CNT_W-1:0] el [2];
    logic [CNT_W-1:0] ld [2];
    logic             lv [2];
    logic             lf [2];
    logic             drop [2];
    logic             ovf [2];

    int passed = 0;
    int total  = 0;

    bit          m_meas;
    int          m_cnt [2];
    int          m_el [2];
    bit          m_ovf [2];
    bit          m_drop [2];
    int unsigned m_q [2][$];

    always #5 clk = ~clk;

    ro_lap_timer #(.CNT_W(CNT_W), .SHORT_W(4), .LAPS(LAPS), .SAT(1'b0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .clear(clear), .start(start), .stop(stop), .lap(lap), .rd_en(rd_en),
        .measuring(meas[0]), .elapsed_count(el[0]), .lap_data(ld[0]), .lap_valid(lv[0]),
        .lap_full(lf[0]), .lap_dropped(drop[0]), .overflow(ovf[0]));

    ro_lap_timer #(.CNT_W(CNT_W), .SHORT_W(4), .LAPS(LAPS), .SAT(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .clear(clear), .start(start), .stop(stop), .lap(lap), .rd_en(rd_en),
        .measuring(meas[1]), .elapsed_count(el[1]), .lap_data(ld[1]), .lap_valid(lv[1]),
        .lap_full(lf[1]), .lap_dropped(drop[1]), .overflow(ovf[1]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_meas = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_el[k] = 0; m_ovf[k] = 1'b0; m_drop[k] = 1'b0;
            m_q[k].delete();
        end
    endtask

    task automatic model_edge();
        bit run;
        run = m_meas && !clear && !stop;
        for (int k = 0; k < 2; k++) begin
            if (clear) begin
                m_cnt[k] = 0; m_el[k] = 0; m_ovf[k] = 1'b0; m_drop[k] = 1'b0;
                m_q[k].delete();
            end else begin
                if (stop) m_el[k] = m_cnt[k];
                if (rd_en && m_q[k].size() > 0) void'(m_q[k].pop_front());
                if (run && lap) begin
                    if (m_q[k].size() < LAPS) m_q[k].push_back(m_cnt[k]);
                    else m_drop[k] = 1'b1;
                end
                if (run) begin
                    if (m_cnt[k] == MAXV) begin
                        m_ovf[k] = 1'b1;
                        m_cnt[k] = (k == 1) ? MAXV : 0;
                    end else m_cnt[k]++;
                end
            end
        end
        if (!clear) m_meas = stop ? 1'b0 : start ? 1'b1 : m_meas;
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("measuring[%0d]", k), 32'(meas[k]), 32'(m_meas));
            chk($sformatf("elapsed[%0d]", k), 32'(el[k]), 32'(m_el[k]));
            chk($sformatf("lap_data[%0d]", k), 32'(ld[k]), (m_q[k].size() > 0) ? 32'(m_q[k][0]) : 32'd0);
            chk($sformatf("lap_valid[%0d]", k), 32'(lv[k]), 32'(m_q[k].size() > 0));
            chk($sformatf("lap_full[%0d]", k), 32'(lf[k]), 32'(m_q[k].size() == LAPS));
            chk($sformatf("dropped[%0d]", k), 32'(drop[k]), 32'(m_drop[k]));
            chk($sformatf("overflow[%0d]", k), 32'(ovf[k]), 32'(m_ovf[k]));
        end
    endtask

    task automatic step(input bit c, input bit s, input bit st, input bit l, input bit r);
        clear = c; stop = s; start = st; lap = l; rd_en = r;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0; clear = 0; start = 0; stop = 0; lap = 0; rd_en = 0;
        model_reset();
        #12;
        check_all();
        rst_n = 1'b1;
        // basic run / resume / clear
        step(0, 0, 1, 0, 0);
        idle(20);
        step(0, 1, 0, 0, 0);
        chk("elapsed_20", 32'(el[0]), 32'd20);
        step(0, 0, 1, 0, 0);
        idle(5);
        step(0, 1, 0, 0, 0);
        chk("elapsed_25", 32'(el[0]), 32'd25);
        step(1, 0, 0, 0, 0);
        chk("clear_elapsed", 32'(el[0]), 32'd0);
        chk("clear_meas", 32'(meas[0]), 32'd0);
        // low-to-high segment carry
        step(0, 0, 1, 0, 0);
        idle(15);
        step(0, 1, 0, 0, 0);
        chk("elapsed_15", 32'(el[0]), 32'd15);
        step(0, 0, 1, 0, 0);
        idle(1);
        step(0, 1, 0, 0, 0);
        chk("carry_16", 32'(el[0]), 32'd16);
        // overflow wrap vs saturate
        step(0, 0, 1, 0, 0);
        idle(239);
        step(0, 1, 0, 0, 0);
        chk("reach_255", 32'(el[0]), 32'd255);
        chk("no_ovf_yet", 32'(ovf[0]), 32'd0);
        step(0, 0, 1, 0, 0);
        idle(1);
        step(0, 1, 0, 0, 0);
        chk("wrap_count", 32'(el[0]), 32'd0);
        chk("sat_count", 32'(el[1]), 32'd255);
        chk("wrap_ovf", 32'(ovf[0]), 32'd1);
        chk("sat_ovf", 32'(ovf[1]), 32'd1);
        step(1, 0, 0, 0, 0);
        chk("ovf_cleared", 32'(ovf[1]), 32'd0);
        // lap capture, fill, drop, drain
        step(0, 0, 1, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, (i % 4) == 3, 0);
        chk("laps_full", 32'(lf[0]), 32'd1);
        chk("laps_dropped", 32'(drop[0]), 32'd1);
        step(0, 1, 0, 0, 0);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("drain_%0d", j), 32'(ld[0]), 32'(3 + 4 * j));
            step(0, 0, 0, 0, 1);
        end
        chk("drained_valid", 32'(lv[0]), 32'd0);
        // push and pop together on a full FIFO
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1);
        chk("pushpop_full", 32'(lf[0]), 32'd1);
        chk("pushpop_nodrop", 32'(drop[0]), 32'd0);
        chk("pushpop_head", 32'(ld[0]), 32'd1);
        step(0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        chk("clear_beats_start", 32'(meas[0]), 32'd0);
        // asynchronous reset mid-count with two entries
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        idle(3);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("async_valid", 32'(lv[0]), 32'd0);
        #2 rst_n = 1'b1;
        idle(1);
        chk("post_reset_valid", 32'(lv[1]), 32'd0);
        // randomized traffic against the reference model
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 39) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
